// File: rtl/uart_rx_led_timer.sv
// ============================================================================
// uart_rx_led_timer : UART receive activity LED with per-mode hold timer,
//                     last-byte latch, saturating byte count, mode-change flag
// Revision 1.0
// ============================================================================
`default_nettype none

module uart_rx_led_timer #(
    parameter int CLKS_PER_UNIT = 2500000,
    parameter int SEL_W         = 2,
    parameter int CNT_W         = 16,
    parameter int RETRIGGER     = 1
) (
    input  logic                  i_Clock,
    input  logic                  i_Rst_n,
    input  logic                  i_Rx_DV,
    input  logic [7:0]            i_Rx_Byte,
    input  logic [SEL_W-1:0]      i_baud_select,
    output logic [2**SEL_W-1:0]   o_led,
    output logic                  o_active,
    output logic [CNT_W-1:0]      o_byte_count,
    output logic [7:0]            o_last_byte,
    output logic                  o_mode_change
);

    localparam int NUM_MODES = 2**SEL_W;
    localparam int TIMER_W   = $clog2(NUM_MODES*CLKS_PER_UNIT+1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]           state, state_nx;
    logic [TIMER_W-1:0]   timer, timer_nx;
    logic [SEL_W-1:0]     sel_q, sel_nx;
    logic [NUM_MODES-1:0] led_nx, led_onehot;
    logic [CNT_W-1:0]     count_nx;
    logic [7:0]           last_nx;
    logic                 mc_nx, active_nx;
    logic                 mode_chg, accept;
    logic [TIMER_W-1:0]   hold_load;

    assign mode_chg  = (i_baud_select != sel_q);
    assign accept    = i_Rx_DV & ~mode_chg;
    // HOLD(m)-1 = (m+1)*CLKS_PER_UNIT-1, loaded so the LED stays lit HOLD(m) cycles
    assign hold_load = TIMER_W'((32'(sel_q) + 32'd1) * 32'(CLKS_PER_UNIT) - 32'd1);

    always_comb begin
        led_onehot        = '0;
        led_onehot[sel_q] = 1'b1;
    end

    // State and output registers
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state         <= IDLE;
            timer         <= '0;
            sel_q         <= i_baud_select;
            o_led         <= '0;
            o_active      <= 1'b0;
            o_byte_count  <= '0;
            o_last_byte   <= '0;
            o_mode_change <= 1'b0;
        end else begin
            state         <= state_nx;
            timer         <= timer_nx;
            sel_q         <= sel_nx;
            o_led         <= led_nx;
            o_active      <= active_nx;
            o_byte_count  <= count_nx;
            o_last_byte   <= last_nx;
            o_mode_change <= mc_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        if (mode_chg) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nx = HOLD;
                HOLD:    if (timer == '0 && !accept) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        timer_nx  = timer;
        sel_nx    = sel_q;
        led_nx    = o_led;
        count_nx  = o_byte_count;
        last_nx   = o_last_byte;
        mc_nx     = 1'b0;
        active_nx = (state_nx == HOLD);

        if (mode_chg) begin
            sel_nx   = i_baud_select;
            mc_nx    = 1'b1;
            led_nx   = '0;
            timer_nx = '0;
            count_nx = '0;
        end else begin
            if (accept) begin
                last_nx  = i_Rx_Byte;
                count_nx = (&o_byte_count) ? o_byte_count : o_byte_count + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        timer_nx = hold_load;
                        led_nx   = led_onehot;
                    end
                end
                HOLD: begin
                    // A byte landing on the expiry cycle restarts the hold regardless of RETRIGGER
                    if (timer == '0) begin
                        if (accept) begin
                            timer_nx = hold_load;
                            led_nx   = led_onehot;
                        end else begin
                            led_nx   = '0;
                        end
                    end else if (accept && (RETRIGGER != 0)) begin
                        timer_nx = hold_load;
                    end else begin
                        timer_nx = timer - TIMER_W'(1);
                    end
                end
                default: begin
                    led_nx   = '0;
                    timer_nx = '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_led_timer.md
Name: uart_rx_led_timer

Overview:
Parametrised activity indicator fed by the UART receiver's data-valid strobe. Each received byte lights the one-hot LED of the current baud mode for a mode-dependent hold time, then the LED turns off automatically. The block also latches the last byte, keeps a saturating byte count, and flags baud-mode changes. It sits in the top level beside the urx/utx pair and drives the board LEDs.

Parameters:
CLKS_PER_UNIT, 2500000, clock cycles per hold unit; hold time for mode m is HOLD(m) = (m+1)*CLKS_PER_UNIT cycles.
SEL_W, 2, baud_select width; NUM_MODES = 2**SEL_W LEDs.
CNT_W, 16, byte counter width.
RETRIGGER, 1, 1 = a byte during hold restarts the hold; 0 = the hold is not extended.

Ports:
i_Clock  input  1  system clock, all logic on rising edge
i_Rst_n  input  1  synchronous reset, active-low
i_Rx_DV  input  1  one-cycle strobe from receiver: byte valid
i_Rx_Byte  input  8  received byte, valid when i_Rx_DV=1
i_baud_select  input  SEL_W  current baud mode
o_led  output  NUM_MODES  one-hot activity LEDs, bit = registered mode
o_active  output  1  high while in HOLD
o_byte_count  output  CNT_W  bytes accepted since reset or last mode change, saturating
o_last_byte  output  8  most recently accepted byte
o_mode_change  output  1  one-cycle pulse after a baud_select change

Behaviour:
- Reset (i_Rst_n=0 at a clock edge): o_led=0, o_active=0, o_byte_count=0, o_last_byte=0, o_mode_change=0, state=IDLE, timer=0, sel_q=i_baud_select. Reset mid-hold turns the LED off on the next edge.
- All outputs are registered. Timer width is clog2(NUM_MODES*CLKS_PER_UNIT+1).
- sel_q is the registered mode. The block compares i_baud_select against sel_q every cycle.
- Mode change has the highest priority after reset. When i_baud_select != sel_q:
  - sel_q <= i_baud_select and o_mode_change <= 1 for exactly one cycle.
  - o_led <= 0, state <= IDLE, timer <= 0, o_byte_count <= 0.
  - An i_Rx_DV in the same cycle is dropped: no count, no latch.
- Accepted byte (i_Rx_DV=1, no mode change):
  - o_last_byte <= i_Rx_Byte.
  - o_byte_count increments, holding at all-ones once saturated.
- IDLE:
  - On an accepted byte: timer <= HOLD(sel_q)-1, o_led <= one-hot(sel_q), state <= HOLD.
  - The LED rises on the edge after the DV cycle (latency 1).
- HOLD:
  - The timer decrements each cycle.
  - When timer==0 with no accepted byte: o_led <= 0, state <= IDLE. The LED is therefore high for exactly HOLD(sel_q) cycles.
  - Accepted byte with RETRIGGER=1: timer <= HOLD(sel_q)-1. The LED stays on with no gap.
  - Accepted byte with RETRIGGER=0: the timer is unaffected, but the byte is still counted and latched.
  - Accepted byte on the cycle timer==0, either RETRIGGER value: treated as a new start. The timer reloads and the LED stays on.
- o_active is high exactly when state==HOLD. o_led is nonzero only in HOLD.
- Only one LED is ever lit. Back-to-back DV on consecutive cycles is legal and every strobe is counted.

Test Plan:
(CLKS_PER_UNIT=4, SEL_W=2, CNT_W=4 for simulation)
1. Reset with sel=0, then one DV with byte 0x41 -> o_led=4'b0001 from the next edge for exactly 4 cycles, then 0. o_last_byte=0x41, o_byte_count=1, o_active mirrors the LED.
2. sel=3, one DV -> o_led=4'b1000 high for exactly 16 cycles. Then sel=1, one DV -> 4'b0010 high for 8 cycles.
3. Retrigger, sel=0:
   - RETRIGGER=1: DV at t0 and at t0+3 -> LED continuously high until t0+7 inclusive, then off.
   - RETRIGGER=0, same stimulus -> LED off after t0+4. Count is 2 in both cases.
   - DV exactly on the timer==0 cycle -> LED has no gap.
4. Mode change: during HOLD in mode 2, change sel to 1 with a simultaneous DV (byte 0x55) -> next edge o_led=0, o_mode_change=1 for one cycle, o_byte_count=0, o_last_byte unchanged.
5. Saturation: 20 consecutive-cycle DV strobes -> o_byte_count stops at 15, and every strobe updates o_last_byte.
6. Assert i_Rst_n=0 mid-hold for one cycle -> all outputs 0 on the next edge, and the next DV starts a full-length hold.
